ap3_sync_fifo: RTL and testbench

- Parametrised single-clock FIFO simulation model for the AP3 cell library.
- Successor to the fixed 32-bit RAM/FIFO blackbox in FIFO mode, with generic width and depth and an optional first-word-fall-through read port.
- Adds a synchronous flush, programmable almost-empty/almost-full thresholds, an occupancy count and sticky overflow/underflow error flags.
- Used by synthesis-mapped FIFO instances and by behavioural testbenches.

---
 rtl/ap3_sync_fifo.sv | 108 ++++++++++
 tb/tb_ap3_sync_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ap3_sync_fifo.sv
// Parametrised single-clock FIFO with optional first-word-fall-through read port,
// synchronous flush, programmable almost-empty/almost-full thresholds and sticky error flags.
module ap3_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic [ADDR_WIDTH-1:0] upae,
    input  logic [ADDR_WIDTH-1:0] upaf,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int                 DEPTH_N = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [0:DEPTH_N-1];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  wr_ok;
    logic                  rd_ok;

    // Handshake: wen/ren are requests sampled at posedge; a write is taken only when
    // !full and a read only when !empty, both judged on the count before the edge.
    // There is no backpressure beyond full/empty, and flush overrides both requests.
    assign wr_ok = rst_n & ~flush & wen & ~full;
    assign rd_ok = rst_n & ~flush & ren & ~empty;

    assign count        = cnt;
    assign empty        = (cnt == '0);
    assign full         = (cnt == DEPTH);
    assign almost_empty = (cnt <= {1'b0, upae});
    assign almost_full  = (cnt >= (DEPTH - {1'b0, upaf}));

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (wen && full) begin
                overflow <= 1'b1;
            end
            if (ren && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head entry is always visible; stale when empty.
            assign rdata = mem[rptr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (flush) begin
                    rdata_q <= '0;
                end else if (rd_ok) begin
                    rdata_q <= mem[rptr];
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate
endmodule

// File: tb/tb_ap3_sync_fifo.sv
// Directed bench for ap3_sync_fifo: depth-4, 8-bit instances with registered and
// first-word-fall-through read ports driven by the same stimulus.
module tb_ap3_sync_fifo;
    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       wen;
    logic [7:0] wdata;
    logic       ren;
    logic [1:0] upae;
    logic [1:0] upaf;

    logic [7:0] rdata;
    logic [2:0] count;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;

    logic [7:0] rdata_f;
    logic [2:0] count_f;
    logic       empty_f, full_f, almost_empty_f, almost_full_f, overflow_f, underflow_f;

    int n_cmp;
    int n_err;

    ap3_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata), .upae(upae), .upaf(upaf), .count(count), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow)
    );

    ap3_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata_f), .upae(upae), .upaf(upaf), .count(count_f), .empty(empty_f),
        .full(full_f), .almost_empty(almost_empty_f), .almost_full(almost_full_f),
        .overflow(overflow_f), .underflow(underflow_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Let one posedge pass with the currently driven inputs, then sample 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic f);
        wen   = w;
        wdata = d;
        ren   = r;
        flush = f;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        upae  = 2'd1;
        upaf  = 2'd1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset state
        #12;
        check("rst_empty", 8'(empty), 8'd1);
        check("rst_full", 8'(full), 8'd0);
        check("rst_count", 8'(count), 8'd0);
        check("rst_ae", 8'(almost_empty), 8'd1);
        check("rst_af", 8'(almost_full), 8'd0);
        check("rst_ovf", 8'(overflow), 8'd0);
        check("rst_udf", 8'(underflow), 8'd0);
        check("rst_rdata", rdata, 8'h00);
        rst_n = 1'b1;
        cyc();
        check("idle_count", 8'(count), 8'd0);

        // Fill with thresholds upae=1, upaf=1
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        cyc();
        check("w1_count", 8'(count), 8'd1);
        check("w1_ae", 8'(almost_empty), 8'd1);
        check("w1_empty", 8'(empty), 8'd0);
        check("w1_fwft_rdata", rdata_f, 8'h11);
        check("w1_reg_rdata_holds", rdata, 8'h00);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        cyc();
        check("w2_count", 8'(count), 8'd2);
        check("w2_ae", 8'(almost_empty), 8'd0);
        check("w2_af", 8'(almost_full), 8'd0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        cyc();
        check("w3_count", 8'(count), 8'd3);
        check("w3_af", 8'(almost_full), 8'd1);
        upaf = 2'd0;
        #1;
        check("upaf0_af", 8'(almost_full), 8'd0);
        upaf = 2'd1;
        #1;
        check("upaf1_af", 8'(almost_full), 8'd1);
        drive(1'b1, 8'h44, 1'b0, 1'b0);
        cyc();
        check("w4_count", 8'(count), 8'd4);
        check("w4_full", 8'(full), 8'd1);
        check("w4_af", 8'(almost_full), 8'd1);

        // Write rejected on full even though the read in the same cycle is accepted
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        cyc();
        check("ovf_count", 8'(count), 8'd3);
        check("ovf_flag", 8'(overflow), 8'd1);
        check("ovf_rdata", rdata, 8'h11);
        check("ovf_full", 8'(full), 8'd0);
        drive(1'b1, 8'h66, 1'b0, 1'b0);
        cyc();
        check("w66_count", 8'(count), 8'd4);
        check("w66_rdata_holds", rdata, 8'h11);
        check("ovf_sticky", 8'(overflow), 8'd1);

        // Drain: order 22,33,44,66 (0x55 must not appear)
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        cyc();
        check("rd1_rdata", rdata, 8'h22);
        cyc();
        check("rd2_rdata", rdata, 8'h33);
        cyc();
        check("rd3_rdata", rdata, 8'h44);
        check("rd3_fwft_head", rdata_f, 8'h66);
        cyc();
        check("rd4_rdata", rdata, 8'h66);
        check("drained_empty", 8'(empty), 8'd1);
        check("drained_count", 8'(count), 8'd0);
        check("drained_udf", 8'(underflow), 8'd0);

        // Read on empty
        cyc();
        check("udf_flag", 8'(underflow), 8'd1);
        check("udf_count", 8'(count), 8'd0);
        check("udf_rdata_holds", rdata, 8'h66);
        check("udf_flag_fwft", 8'(underflow_f), 8'd1);

        // Flush beats a write in the same cycle and clears error flags
        drive(1'b1, 8'h77, 1'b0, 1'b1);
        cyc();
        check("fl_count", 8'(count), 8'd0);
        check("fl_empty", 8'(empty), 8'd1);
        check("fl_ovf", 8'(overflow), 8'd0);
        check("fl_udf", 8'(underflow), 8'd0);
        check("fl_rdata", rdata, 8'h00);

        // FWFT: written word visible without ren
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        cyc();
        check("fwft_rdata", rdata_f, 8'hA5);
        check("fwft_count", 8'(count_f), 8'd1);
        check("reg_rdata_no_ren", rdata, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        cyc();
        check("a5_read_rdata", rdata, 8'hA5);
        check("a5_read_count", 8'(count), 8'd0);

        // Wrap: 6 writes / 5 reads interleaved, pointers start at 1 and pass 3
        drive(1'b1, 8'h80, 1'b0, 1'b0);
        cyc();
        check("wrap_w0_count", 8'(count), 8'd1);
        for (int i = 1; i < 6; i++) begin
            drive(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            cyc();
            check($sformatf("wrap_rd%0d", i), rdata, 8'(8'h80 + i - 1));
            check($sformatf("wrap_cnt%0d", i), 8'(count), 8'd1);
        end
        check("wrap_fwft_head", rdata_f, 8'h85);
        check("wrap_ovf", 8'(overflow), 8'd0);

        // Asynchronous reset mid-stream clears state before the next edge
        drive(1'b1, 8'h99, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 8'(count), 8'd0);
        check("arst_empty", 8'(empty), 8'd1);
        check("arst_rdata", rdata, 8'h00);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        cyc();
        check("arst_hold_count", 8'(count), 8'd0);
        rst_n = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
